fpu_issue_ctrl: RTL and testbench

- Issue and completion controller for the FPU. Accepts one operation per cycle over a valid/ready handshake and routes it to exactly one functional unit (adder, multiplier, div/sqrt, min/max selector, comparator, converter).
- Records the issue order in a tag FIFO and returns results strictly in program order through a registered output stage.
- Flush support lets the core discard all in-flight FPU work.

---
 rtl/fpu_issue_ctrl_pkg.sv | 51 +++++
 rtl/fpu_issue_ctrl_tag_fifo.sv | 55 +++++
 rtl/fpu_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared opcode encoding, unit indices and the opcode-to-unit routing table
// for the FPU issue/completion controller.
package fpu_issue_ctrl_pkg;

  typedef logic [2:0] unit_t;

  localparam unit_t UNIT_ADD     = 3'd0;
  localparam unit_t UNIT_MUL     = 3'd1;
  localparam unit_t UNIT_DIVSQRT = 3'd2;
  localparam unit_t UNIT_SEL     = 3'd3;
  localparam unit_t UNIT_CMP     = 3'd4;
  localparam unit_t UNIT_CVT     = 3'd5;
  localparam unit_t UNIT_NONE    = 3'd7;

  // Flags of an unmapped op: invalid-operation only.
  localparam logic [4:0] FFLAGS_NV = 5'b10000;

  typedef enum logic [4:0] {
    FPU_OP_ADD      = 5'd0,
    FPU_OP_SUB      = 5'd1,
    FPU_OP_MUL      = 5'd2,
    FPU_OP_DIV      = 5'd3,
    FPU_OP_SQRT     = 5'd4,
    FPU_OP_MIN      = 5'd5,
    FPU_OP_MAX      = 5'd6,
    FPU_OP_FEQ      = 5'd7,
    FPU_OP_FLT      = 5'd8,
    FPU_OP_FLE      = 5'd9,
    FPU_OP_CVT_W_S  = 5'd10,
    FPU_OP_CVT_WU_S = 5'd11,
    FPU_OP_CVT_S_W  = 5'd12,
    FPU_OP_CVT_S_WU = 5'd13
  } fpu_op_e;

  // Every opcode not listed routes to UNIT_NONE and completes as an illegal op.
  function automatic unit_t fpu_unit_of(input logic [4:0] op);
    unit_t u;
    case (op)
      FPU_OP_ADD, FPU_OP_SUB:                   u = UNIT_ADD;
      FPU_OP_MUL:                               u = UNIT_MUL;
      FPU_OP_DIV, FPU_OP_SQRT:                  u = UNIT_DIVSQRT;
      FPU_OP_MIN, FPU_OP_MAX:                   u = UNIT_SEL;
      FPU_OP_FEQ, FPU_OP_FLT, FPU_OP_FLE:       u = UNIT_CMP;
      FPU_OP_CVT_W_S, FPU_OP_CVT_WU_S,
      FPU_OP_CVT_S_W, FPU_OP_CVT_S_WU:          u = UNIT_CVT;
      default:                                  u = UNIT_NONE;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_tag_fifo.sv
// Program-order record of which unit owns each in-flight operation.
module fpu_tag_fifo
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  push,
  input  logic  pop,
  input  unit_t din,
  output unit_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  unit_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count resolves full vs empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Overflow and underflow are controller bugs, never legal traffic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop && empty)) else $error("tag fifo pop while empty");
      assert (!(push && full)) else $error("tag fifo push while full");
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue and in-order completion controller: routes each accepted op to one
// functional unit, remembers issue order, and retires results in that order.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int N_UNITS = 6,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [4:0]           op,
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  output logic [4:0]           op_unit,
  output logic [N_UNITS-1:0]   unit_valid,
  input  logic [N_UNITS-1:0]   unit_ready,
  input  logic [N_UNITS-1:0]   unit_res_valid,
  output logic [N_UNITS-1:0]   unit_res_ready,
  input  logic [32*N_UNITS-1:0] unit_float,
  input  logic [5*N_UNITS-1:0] unit_fflags,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [31:0]          float_out,
  output logic [4:0]           fflags,
  output logic                 illegal_op
);

  unit_t       sel;
  unit_t       head;
  logic        full;
  logic        empty;
  logic        sel_ready;
  logic        head_res_valid;
  logic [31:0] head_float;
  logic [4:0]  head_flags;
  logic        head_none;
  logic        can_load;
  logic        load;
  logic        accept;
  logic        push;
  logic        pop;

  // Operands go to the units on their own wires; this block only routes by opcode.
  logic unused_operands;
  assign unused_operands = ^{a, b};

  assign op_unit   = op;
  assign sel       = fpu_unit_of(op);
  assign ready_out = !full && ((sel == UNIT_NONE) || sel_ready);
  assign accept    = valid_in && ready_out;
  assign head_none = (head == UNIT_NONE);
  assign can_load  = !empty && (!valid_out || ready_in);
  assign load      = can_load && (head_none || head_res_valid);
  assign push      = accept && !flush;
  assign pop       = load && !flush;

  // Issue side: pick the selected unit's ready and raise its strobe.
  always_comb begin
    sel_ready  = 1'b0;
    unit_valid = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (sel == unit_t'(i)) begin
        sel_ready     = unit_ready[i];
        unit_valid[i] = valid_in && !full;
      end
    end
  end

  // Completion side: only the unit owning the oldest op is acknowledged, so others hold.
  always_comb begin
    unit_res_ready = '0;
    head_res_valid = 1'b0;
    head_float     = '0;
    head_flags     = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (head == unit_t'(i)) begin
        unit_res_ready[i] = can_load;
        head_res_valid    = unit_res_valid[i];
        head_float        = unit_float[32*i +: 32];
        head_flags        = unit_fflags[5*i +: 5];
      end
    end
  end

  fpu_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Registered result stage; a load overrides a drain so results can go back to back.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_out  <= 1'b0;
      float_out  <= '0;
      fflags     <= '0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept && (sel == UNIT_NONE);
      if (load) begin
        valid_out <= 1'b1;
        float_out <= head_none ? 32'h0 : head_float;
        fflags    <= head_none ? FFLAGS_NV : head_flags;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
        float_out <= '0;
        fflags    <= '0;
      end
    end
  end

  // Issue strobes and result acknowledges never address more than one unit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(unit_valid))     else $error("unit_valid not one-hot");
      assert ($onehot0(unit_res_ready)) else $error("unit_res_ready not one-hot");
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: behavioural functional units plus an in-order
// queue model of what must come out and when.
module tb_fpu_issue_ctrl;

  localparam int NU    = 6;
  localparam int DEPTH = 4;
  localparam int NONE  = 7;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MIN = 5'd5;
  localparam logic [4:0] OP_MAX = 5'd6;

  logic                 clk = 1'b0;
  logic                 reset, flush, valid_in, ready_out, ready_in;
  logic [4:0]           op, op_unit;
  logic [31:0]          a, b, float_out;
  logic [NU-1:0]        unit_valid, unit_ready, unit_res_valid, unit_res_ready;
  logic [32*NU-1:0]     unit_float;
  logic [5*NU-1:0]      unit_fflags;
  logic                 valid_out, illegal_op;
  logic [4:0]           fflags;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.N_UNITS(NU), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
    .op(op), .a(a), .b(b), .op_unit(op_unit), .unit_valid(unit_valid), .unit_ready(unit_ready),
    .unit_res_valid(unit_res_valid), .unit_res_ready(unit_res_ready), .unit_float(unit_float),
    .unit_fflags(unit_fflags), .valid_out(valid_out), .ready_in(ready_in), .float_out(float_out),
    .fflags(fflags), .illegal_op(illegal_op)
  );

  typedef struct {
    int          u;
    logic [31:0] f;
    logic [4:0]  fl;
    int          done;
  } ent_t;

  ent_t         uq[$];      // results held inside the behavioural units
  ent_t         pq[$];      // accepted ops not yet in the output register
  logic [36:0]  outlog[$];  // {fflags, float} of every result the consumer took
  logic         m_v, m_ill;
  logic [31:0]  m_f;
  logic [4:0]   m_fl;
  int           errors = 0, checks = 0, cyc = 0, ill_seen = 0, cap = 4;
  bit           rnd_ready = 0, last_acc;

  function automatic int ref_unit(input logic [4:0] o);
    case (o)
      5'd0, 5'd1:                 return 0;
      5'd2:                       return 1;
      5'd3, 5'd4:                 return 2;
      5'd5, 5'd6:                 return 3;
      5'd7, 5'd8, 5'd9:           return 4;
      5'd10, 5'd11, 5'd12, 5'd13: return 5;
      default:                    return NONE;
    endcase
  endfunction

  function automatic int lat(input int u);
    case (u)
      0: return 3;
      1: return 4;
      2: return 10;
      5: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic [32:0] ord_key(input logic [31:0] x);
    return x[31] ? {1'b0, ~x} : {1'b1, x};
  endfunction

  // Behavioural result of unit u; the selector implements IEEE minNum/maxNum.
  task automatic unit_result(input int u, input logic [4:0] o, input logic [31:0] x,
                             input logic [31:0] y, output logic [31:0] f, output logic [4:0] fl);
    bit nv;
    if (u == NONE) begin
      f = 32'h0; fl = 5'b10000;
    end else if (u == 3) begin
      nv = (is_nan(x) && !x[22]) || (is_nan(y) && !y[22]);
      if (is_nan(x) && is_nan(y))   f = 32'h7fc00000;
      else if (is_nan(x))           f = y;
      else if (is_nan(y))           f = x;
      else if (o == OP_MAX)         f = (ord_key(x) > ord_key(y)) ? x : y;
      else                          f = (ord_key(x) < ord_key(y)) ? x : y;
      fl = {nv, 4'b0000};
    end else begin
      f  = x ^ {y[15:0], y[31:16]} ^ (32'h11111111 * u);
      fl = x[4:0] ^ 5'(u);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the units, check every output against the model, advance the model.
  task automatic tick();
    int j, cnt, u, hu;
    bit full_m, can_load, acc, ld, dr;
    logic [NU-1:0] exp_uv, exp_urr;
    logic exp_ready;
    logic [31:0] rf;
    logic [4:0]  rfl;
    ent_t e;
    for (int i = 0; i < NU; i++) begin
      cnt = 0; j = -1;
      for (int k = 0; k < uq.size(); k++)
        if (uq[k].u == i) begin
          if (j < 0) j = k;
          cnt++;
        end
      if (j >= 0) begin
        unit_res_valid[i]       = (uq[j].done <= cyc);
        unit_float[32*i +: 32]  = uq[j].f;
        unit_fflags[5*i +: 5]   = uq[j].fl;
      end else begin
        unit_res_valid[i]       = 1'b0;
        unit_float[32*i +: 32]  = 32'h0;
        unit_fflags[5*i +: 5]   = 5'h0;
      end
      unit_ready[i] = (cnt < cap) && (!rnd_ready || ($urandom % 4 != 0));
    end
    #1;
    u         = ref_unit(op);
    full_m    = (pq.size() >= DEPTH);
    exp_ready = !full_m && (u == NONE || unit_ready[u]);
    exp_uv    = '0;
    if (valid_in && !full_m && u != NONE) exp_uv[u] = 1'b1;
    can_load  = (pq.size() > 0) && (!m_v || ready_in);
    hu        = (pq.size() > 0) ? pq[0].u : NONE;
    exp_urr   = '0;
    if (can_load && hu != NONE) exp_urr[hu] = 1'b1;
    chk("ready_out", 64'(ready_out), 64'(exp_ready));
    chk("unit_valid", 64'(unit_valid), 64'(exp_uv));
    chk("unit_res_ready", 64'(unit_res_ready), 64'(exp_urr));
    chk("valid_out", 64'(valid_out), 64'(m_v));
    chk("float_out", 64'(float_out), 64'(m_f));
    chk("fflags", 64'(fflags), 64'(m_fl));
    chk("illegal_op", 64'(illegal_op), 64'(m_ill));
    chk("op_unit", 64'(op_unit), 64'(op));
    if (illegal_op === 1'b1) ill_seen++;
    acc = valid_in && exp_ready;
    ld  = can_load && (hu == NONE || unit_res_valid[hu]);
    dr  = m_v && ready_in;
    last_acc = acc;
    @(posedge clk);
    if (flush) begin
      pq.delete(); uq.delete();
      m_v = 0; m_f = '0; m_fl = '0; m_ill = 0;
    end else begin
      if (dr) outlog.push_back({m_fl, m_f});
      if (ld) begin
        e = pq.pop_front();
        if (e.u != NONE) begin
          j = -1;
          for (int k = 0; k < uq.size(); k++)
            if (j < 0 && uq[k].u == e.u) j = k;
          if (j >= 0) uq.delete(j);
        end
        m_v = 1; m_f = e.f; m_fl = e.fl;
      end else if (dr) begin
        m_v = 0; m_f = '0; m_fl = '0;
      end
      if (acc) begin
        unit_result(u, op, a, b, rf, rfl);
        pq.push_back('{u, rf, rfl, 0});
        if (u != NONE) uq.push_back('{u, rf, rfl, cyc + lat(u)});
      end
      m_ill = acc && (u == NONE);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid_in = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    bit got = 0;
    op = o; a = x; b = y; valid_in = 1;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      got = last_acc;
    end
    valid_in = 0;
    chk("issue_accepted", 64'(got), 64'd1);
  endtask

  initial begin
    logic [31:0] rf;
    logic [4:0]  rfl;
    int n;
    reset = 1; flush = 0; valid_in = 0; ready_in = 1; op = OP_ADD; a = '0; b = '0;
    unit_ready = '0; unit_res_valid = '0; unit_float = '0; unit_fflags = '0;
    m_v = 0; m_f = '0; m_fl = '0; m_ill = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Reset state
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_float_out", 64'(float_out), 64'd0);
    chk("rst_fflags", 64'(fflags), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    idle(1);

    // MAX(1.0, 2.0) with two-cycle accept-to-result latency
    issue(OP_MAX, 32'h3f800000, 32'h40000000);
    chk("max_t1_valid", 64'(valid_out), 64'd0);
    tick();
    chk("max_t2_valid", 64'(valid_out), 64'd1);
    chk("max_float", 64'(float_out), 64'h40000000);
    chk("max_fflags", 64'(fflags), 64'd0);
    idle(2);

    // MIN with a signalling NaN operand
    issue(OP_MIN, 32'h7fa00000, 32'h3f800000);
    tick();
    chk("min_snan_float", 64'(float_out), 64'h3f800000);
    chk("min_snan_fflags", 64'(fflags), 64'h10);
    idle(2);

    // Long DIV ahead of a quick MIN: MIN must wait its turn
    outlog.delete();
    issue(OP_DIV, 32'h40400000, 32'h3f800000);
    issue(OP_MIN, 32'h3f800000, 32'h40000000);
    tick();
    chk("ooo_min_held", 64'(unit_res_ready[3]), 64'd0);
    idle(14);
    unit_result(2, OP_DIV, 32'h40400000, 32'h3f800000, rf, rfl);
    chk("ooo_count", 64'(outlog.size()), 64'd2);
    if (outlog.size() == 2) begin
      chk("ooo_first_div", 64'(outlog[0]), 64'({rfl, rf}));
      chk("ooo_second_min", 64'(outlog[1]), 64'({5'b0, 32'h3f800000}));
    end

    // Stalled consumer: fill FIFO plus output register, then drain back to back
    outlog.delete();
    ready_in = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      op = OP_MIN; a = 32'h3f800000 + 32'(n); b = 32'h4f000000; valid_in = 1;
      tick();
      if (!last_acc) break;
      n++;
    end
    chk("fill_count", 64'(n), 64'(DEPTH + 1));
    chk("full_blocks", 64'(ready_out), 64'd0);
    valid_in = 0; ready_in = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk("b2b_valid", 64'(valid_out), 64'd1);
      tick();
    end
    chk("b2b_end", 64'(valid_out), 64'd0);
    chk("ready_back", 64'(ready_out), 64'd1);
    chk("b2b_count", 64'(outlog.size()), 64'(DEPTH + 1));
    for (int i = 0; i < outlog.size(); i++)
      chk("b2b_order", 64'(outlog[i]), 64'({5'b0, 32'h3f800000 + 32'(i)}));

    // Unmapped opcode between two MAXes
    outlog.delete(); ill_seen = 0;
    issue(OP_MAX, 32'h3f800000, 32'h40000000);
    issue(5'h1f, 32'h12345678, 32'h9abcdef0);
    issue(OP_MAX, 32'h40400000, 32'h3f800000);
    idle(6);
    chk("illegal_pulses", 64'(ill_seen), 64'd1);
    chk("illegal_seq_count", 64'(outlog.size()), 64'd3);
    if (outlog.size() == 3) begin
      chk("illegal_seq0", 64'(outlog[0]), 64'({5'b0, 32'h40000000}));
      chk("illegal_seq1", 64'(outlog[1]), 64'({5'b10000, 32'h0}));
      chk("illegal_seq2", 64'(outlog[2]), 64'({5'b0, 32'h40400000}));
    end

    // Flush with work in flight and a result waiting
    ready_in = 0;
    issue(OP_MAX, 32'h3f800000, 32'h40000000);
    issue(OP_DIV, 32'h40400000, 32'h40000000);
    issue(OP_MUL, 32'h40000000, 32'h40000000);
    issue(OP_ADD, 32'h3f800000, 32'h3f800000);
    chk("pre_flush_valid", 64'(valid_out), 64'd1);
    flush = 1; tick(); flush = 0;
    chk("post_flush_valid", 64'(valid_out), 64'd0);
    chk("post_flush_ready", 64'(ready_out), 64'd1);
    ready_in = 1;
    issue(OP_MAX, 32'h3f800000, 32'h40000000);
    chk("flush_max_t1", 64'(valid_out), 64'd0);
    tick();
    chk("flush_max_t2", 64'(valid_out), 64'd1);
    chk("flush_max_float", 64'(float_out), 64'h40000000);
    idle(2);

    // Randomized traffic with unit and consumer stalls and occasional flushes
    rnd_ready = 1;
    for (int i = 0; i < 400; i++) begin
      n = int'($urandom % 20);
      op       = (n < 14) ? 5'(n) : 5'($urandom_range(14, 31));
      a        = $urandom;
      b        = $urandom;
      valid_in = ($urandom % 10) < 7;
      ready_in = ($urandom % 4) != 0;
      flush    = ($urandom % 50) == 0;
      tick();
    end
    flush = 0; ready_in = 1; rnd_ready = 0;
    idle(30);
    chk("final_idle", 64'(valid_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
